logic_pod_pattern_gen: RTL and testbench
========================================

// Module: logic_pod_pattern_gen
// PURPOSE
//   Transmit-side counterpart of the logic pod capture path: generates 8 lanes x 20 samples/clk (5 Gsps @ 250 MHz)
//   of test patterns for the pod output OSERDES/LVDS drivers. Used for loopback self-test, deskew calibration and
//   stimulus. Output word format matches the capture path: la_sample_t, bit 0 = earliest sample in time.
// PARAMETERS
//   LANE_INVERT   8'h00   per-lane polarity flip (board P/N swap), applied in the output register
// PORTS
//   clk_250mhz     in   1       sole clock; all logic on rising edge
//   rst            in   1       synchronous, active-high reset
//   cfg_valid      in   1       config offer; accepted when cfg_valid && cfg_ready
//   cfg_ready      out  1       high only in IDLE
//   cfg_mode       in   2       0=CONST 1=SQUARE 2=COUNT 3=PRBS7
//   cfg_lane_en    in   8       lane enable mask; disabled lanes emit 0 (pre-inversion)
//   cfg_const      in   8       per-lane park level (IDLE and CONST mode)
//   cfg_period     in   16      SQUARE period in samples, legal 20..65535
//   cfg_high       in   16      SQUARE high time in samples, legal 0..cfg_period
//   cfg_burst      in   32      RUN length in clocks; 0 = run until stop
//   cfg_err        out  1       1-cycle pulse: offered config rejected
//   start          in   1       IDLE->RUN
//   stop           in   1       RUN->IDLE
//   busy           out  1       high in RUN
//   done           out  1       1-cycle pulse on every RUN->IDLE exit (burst end or stop; not reset)
//   samples        out  8x20    la_sample_t[7:0], registered
//   samples_valid  out  1       high on cycles carrying RUN pattern data
// BEHAVIOUR
//   Reset: state IDLE, shadow config cleared (mode CONST, mask 0, const 0, period 20, high 0, burst 0); cfg_ready=1;
//     cfg_err/busy/done/samples_valid=0; samples[g]={20{LANE_INVERT[g]}}. Reset mid-RUN: IDLE next cycle, no done.
//   FSM IDLE: cfg_ready=1; config accepted on handshake, validated same cycle; invalid -> cfg_err pulse, shadow unchanged.
//     start -> RUN: square phase=0, count=0, PRBS lane g seeded 7'h7F^g, burst counter=cfg_burst. stop ignored.
//     IDLE output: lane g = {20{cfg_const[g] & cfg_lane_en[g]}}, samples_valid=0.
//   FSM RUN: cfg_ready=0 (offers stall); start ignored. Per clock: emit 20 samples, advance generator state.
//     Exit when stop, or cfg_burst!=0 and this is the cfg_burst-th cycle; stop+burst-end same cycle -> one done.
//   Latency: start sampled at edge N -> samples_valid=1 from edge N+2; exactly cfg_burst valid cycles when nonzero.
//     done asserts with the cycle after the last valid word; busy mirrors state (RUN).
//   CONST: lane g = {20{cfg_const[g]}}.
//   SQUARE (all enabled lanes identical): sample i bit = ((ph+i) mod P) < H, where ph+i < 2P (since P>=20)
//     so mod is one conditional subtract; ph <= (ph+20) mod P per clock, 16-bit, wraps cleanly at P=65535.
//   COUNT: sample i of cycle c carries value n=20c+i; lane g bit = n[g]. n is 8-bit, wraps 255->0 (mod 256).
//   PRBS7: per lane x^7+x^6+1 Fibonacci LFSR, output bit = MSB before shift, advanced 20 steps/clk (unrolled).
//   Validation: P<20 or H>P in any mode -> reject; mode 3 without PRBS macro -> reject.
// CONFIGURATION
//   LOGIC_POD_PRBS_EN defined: PRBS7 mode and unrolled LFSRs present.
//   Undefined: no LFSR logic; cfg_mode=3 rejected with cfg_err; all other modes unchanged.
// STRUCTURE
//   LogicPod.svh: la_sample_t (logic[19:0]), LA_SAMPLES_PER_CLK=20, la_patmode_t enum {CONST,SQUARE,COUNT,PRBS7}.
//   Sub-module logic_pod_prbs7_lane (seed, 20-bit/clk step, instanced 8x under LOGIC_POD_PRBS_EN).
//   FSM, square/count generators and output/inversion register in this module.
// TESTING
//   SQUARE P=40 H=20, mask FF, start -> valid words alternate 20'hFFFFF / 20'h00000 on all lanes from N+2.
//   COUNT, burst=3 -> cycle0 lane0=20'hAAAAA, lane1=20'hCCCCC; exactly 3 valid cycles; done one pulse after.
//   cfg P=19, or H=41 with P=40 -> cfg_err 1-cycle pulse, readback shows prior config still in effect.
//   PRBS7 (macro on), burst=100 -> each lane matches scoreboard LFSR seeded 7'h7F^g; macro off -> cfg_err.
//   stop during RUN with burst=0; stop+burst-end same cycle -> single done; cfg_valid in RUN stalls until IDLE.
//   LANE_INVERT=8'h01, CONST 0, mask FF -> lane0=20'hFFFFF others 0; rst mid-RUN -> IDLE, no done.

Source files
------------

// File: rtl/logic_pod_pattern_gen_pkg.sv
// Shared types for the logic pod pattern generator.
// PRBS7 support is built only when LOGIC_POD_PRBS_EN is defined.
package logic_pod_pattern_gen_pkg;

   localparam int unsigned LA_SAMPLES_PER_CLK = 20;
   localparam int unsigned LA_LANES           = 8;
   localparam logic [15:0] LA_MIN_PERIOD      = 16'd20;

   typedef logic [LA_SAMPLES_PER_CLK-1:0] la_sample_t;

   typedef enum logic [1:0] {
      ModeConst  = 2'd0,
      ModeSquare = 2'd1,
      ModeCount  = 2'd2,
      ModePrbs7  = 2'd3
   } la_patmode_t;

   typedef enum logic {
      StIdle,
      StRun
   } pg_state_t;

   // Square generation relies on P >= 20 so (ph+i) mod P is a single conditional subtract.
   function automatic logic cfg_is_legal(input logic [1:0]  mode,
                                         input logic [15:0] period,
                                         input logic [15:0] high,
                                         input logic        prbs_en);
      return (period >= LA_MIN_PERIOD) && (high <= period) &&
             (prbs_en || (la_patmode_t'(mode) != ModePrbs7));
   endfunction

endpackage

// File: rtl/logic_pod_prbs7_lane.sv
// One PRBS7 (x^7+x^6+1, Fibonacci) lane advanced 20 steps per clock.
// Instanced only when LOGIC_POD_PRBS_EN is defined.
module logic_pod_prbs7_lane
   import logic_pod_pattern_gen_pkg::*;
(
   input  logic        clk_250mhz,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   input  logic [6:0]  seed,
   output logic [19:0] bits
);

   logic [6:0] lfsr_q;
   logic [6:0] lfsr_d;

   // Bit 0 is the earliest sample: emit MSB, then shift, twenty times.
   always_comb begin
      lfsr_d = lfsr_q;
      bits   = '0;
      for (int i = 0; i < LA_SAMPLES_PER_CLK; i++) begin
         bits[i] = lfsr_d[6];
         lfsr_d  = {lfsr_d[5:0], lfsr_d[6] ^ lfsr_d[5]};
      end
   end

   always_ff @(posedge clk_250mhz) begin
      if (rst) begin
         lfsr_q <= 7'h7f;
      end else if (load) begin
         lfsr_q <= seed;
      end else if (advance) begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/logic_pod_pattern_gen.sv
// Logic pod transmit pattern generator: 8 lanes x 20 samples/clk of test patterns.
// Define LOGIC_POD_PRBS_EN to build the PRBS7 mode; otherwise mode 3 is rejected.
module logic_pod_pattern_gen
   import logic_pod_pattern_gen_pkg::*;
#(
   parameter logic [7:0] LANE_INVERT = 8'h00
) (
   input  logic             clk_250mhz,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [7:0]       cfg_lane_en,
   input  logic [7:0]       cfg_const,
   input  logic [15:0]      cfg_period,
   input  logic [15:0]      cfg_high,
   input  logic [31:0]      cfg_burst,
   output logic             cfg_err,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             done,
   output logic [7:0][19:0] samples,
   output logic             samples_valid
);

   pg_state_t        state_q;
   la_patmode_t      mode_q;
   logic [7:0]       lane_en_q, const_q;
   logic [15:0]      period_q, high_q, ph_q, ph_next;
   logic [31:0]      burst_q, burst_cnt_q;
   logic [7:0]       cnt_q;
   logic [7:0][19:0] pat_q, run_word, park_word, cnt_word, prbs_word;
   logic [19:0]      sq_word;
   logic             pat_valid_q, exit_q, exit_q2, cfg_ok;

`ifdef LOGIC_POD_PRBS_EN
   localparam logic PRBS_EN = 1'b1;
   for (genvar g = 0; g < LA_LANES; g++) begin : g_prbs
      logic_pod_prbs7_lane u_lane (
         .clk_250mhz (clk_250mhz),
         .rst        (rst),
         .load       ((state_q == StIdle) && start),
         .advance    (state_q == StRun),
         .seed       (7'h7f ^ 7'(g)),
         .bits       (prbs_word[g])
      );
   end
`else
   localparam logic PRBS_EN = 1'b0;
   assign prbs_word = '0;
`endif

   assign cfg_ok    = cfg_is_legal(cfg_mode, cfg_period, cfg_high, PRBS_EN);
   assign cfg_ready = (state_q == StIdle);
   assign busy      = (state_q == StRun);

   always_comb begin : p_pattern
      logic [16:0] s;
      logic [7:0]  n;
      sq_word   = '0;
      cnt_word  = '0;
      run_word  = '0;
      park_word = '0;
      s = {1'b0, ph_q} + 17'd20;
      ph_next = (s >= {1'b0, period_q}) ? 16'(s - {1'b0, period_q}) : s[15:0];
      for (int i = 0; i < LA_SAMPLES_PER_CLK; i++) begin
         s = {1'b0, ph_q} + 17'(i);
         if (s >= {1'b0, period_q}) s = s - {1'b0, period_q};
         sq_word[i] = (s[15:0] < high_q);
         n = cnt_q + 8'(i);
         for (int g = 0; g < LA_LANES; g++) cnt_word[g][i] = n[g];
      end
      for (int g = 0; g < LA_LANES; g++) begin
         case (mode_q)
            ModeConst:  run_word[g] = {LA_SAMPLES_PER_CLK{const_q[g]}};
            ModeSquare: run_word[g] = sq_word;
            ModeCount:  run_word[g] = cnt_word[g];
            default:    run_word[g] = prbs_word[g];
         endcase
         run_word[g]  = run_word[g] & {LA_SAMPLES_PER_CLK{lane_en_q[g]}};
         park_word[g] = {LA_SAMPLES_PER_CLK{const_q[g] & lane_en_q[g]}};
      end
   end

   // Pipeline: generator -> pat_q -> samples, so data lands two edges after start.
   always_ff @(posedge clk_250mhz) begin
      if (rst) begin
         state_q       <= StIdle;
         mode_q        <= ModeConst;
         lane_en_q     <= '0;
         const_q       <= '0;
         period_q      <= LA_MIN_PERIOD;
         high_q        <= '0;
         burst_q       <= '0;
         ph_q          <= '0;
         cnt_q         <= '0;
         burst_cnt_q   <= '0;
         pat_q         <= '0;
         pat_valid_q   <= 1'b0;
         exit_q        <= 1'b0;
         exit_q2       <= 1'b0;
         cfg_err       <= 1'b0;
         done          <= 1'b0;
         samples_valid <= 1'b0;
         for (int g = 0; g < LA_LANES; g++) begin
            samples[g] <= {LA_SAMPLES_PER_CLK{LANE_INVERT[g]}};
         end
      end else begin
         cfg_err     <= 1'b0;
         exit_q      <= 1'b0;
         pat_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               pat_q <= park_word;
               if (cfg_valid) begin
                  if (cfg_ok) begin
                     mode_q    <= la_patmode_t'(cfg_mode);
                     lane_en_q <= cfg_lane_en;
                     const_q   <= cfg_const;
                     period_q  <= cfg_period;
                     high_q    <= cfg_high;
                     burst_q   <= cfg_burst;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
               if (start) begin
                  state_q     <= StRun;
                  ph_q        <= '0;
                  cnt_q       <= '0;
                  burst_cnt_q <= burst_q;
               end
            end
            default: begin
               pat_q       <= run_word;
               pat_valid_q <= 1'b1;
               ph_q        <= ph_next;
               cnt_q       <= cnt_q + 8'd20;
               burst_cnt_q <= burst_cnt_q - 32'd1;
               if (stop || ((burst_q != '0) && (burst_cnt_q == 32'd1))) begin
                  state_q <= StIdle;
                  exit_q  <= 1'b1;
               end
            end
         endcase
         exit_q2       <= exit_q;
         done          <= exit_q2;
         samples_valid <= pat_valid_q;
         for (int g = 0; g < LA_LANES; g++) begin
            samples[g] <= pat_q[g] ^ {LA_SAMPLES_PER_CLK{LANE_INVERT[g]}};
         end
      end
   end

endmodule

// File: tb/tb_logic_pod_pattern_gen.sv
// Directed bench for logic_pod_pattern_gen; PRBS checks follow LOGIC_POD_PRBS_EN.
module tb_logic_pod_pattern_gen;

   localparam logic [7:0] INV = 8'h01;

   logic             clk_250mhz = 1'b0;
   logic             rst, cfg_valid, cfg_ready, cfg_err, start, stop, busy, done, samples_valid;
   logic [1:0]       cfg_mode;
   logic [7:0]       cfg_lane_en, cfg_const;
   logic [15:0]      cfg_period, cfg_high;
   logic [31:0]      cfg_burst;
   logic [7:0][19:0] samples;

   always #2 clk_250mhz = ~clk_250mhz;

   logic_pod_pattern_gen #(.LANE_INVERT(INV)) dut (
      .clk_250mhz    (clk_250mhz),
      .rst           (rst),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_mode      (cfg_mode),
      .cfg_lane_en   (cfg_lane_en),
      .cfg_const     (cfg_const),
      .cfg_period    (cfg_period),
      .cfg_high      (cfg_high),
      .cfg_burst     (cfg_burst),
      .cfg_err       (cfg_err),
      .start         (start),
      .stop          (stop),
      .busy          (busy),
      .done          (done),
      .samples       (samples),
      .samples_valid (samples_valid)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [7:0]  en;
      logic [7:0]  cval;
      logic [15:0] period;
      logic [15:0] high;
      logic        err;
      logic [7:0]  park;
   } cfg_vec_t;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [1:0] m_mode;
   logic [7:0] m_en, m_const;
   int         m_p, m_h;
   logic [6:0] lf [8];

   task automatic cycle();
      @(posedge clk_250mhz);
      #1;
   endtask

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [159:0] finish_word(input logic [159:0] raw);
      logic [7:0][19:0] w;
      logic [7:0]       inv;
      inv = INV;
      w   = raw;
      for (int g = 0; g < 8; g++) w[g] = (w[g] & {20{m_en[g]}}) ^ {20{inv[g]}};
      return w;
   endfunction

   function automatic logic [159:0] park(input logic [7:0] lv);
      logic [7:0][19:0] w;
      logic [7:0]       inv;
      inv = INV;
      for (int g = 0; g < 8; g++) w[g] = {20{lv[g] ^ inv[g]}};
      return w;
   endfunction

   function automatic logic [159:0] model_word(input int c);
      logic [7:0][19:0] w;
      int               ph, n;
      w  = '0;
      ph = (20 * c) % m_p;
      for (int g = 0; g < 8; g++) begin
         for (int i = 0; i < 20; i++) begin
            n = (20 * c + i) % 256;
            case (m_mode)
               2'd0:    w[g][i] = m_const[g];
               2'd1:    w[g][i] = (((ph + i) % m_p) < m_h);
               default: w[g][i] = n[g];
            endcase
         end
      end
      return w;
   endfunction

   task automatic prbs_model(output logic [159:0] raw);
      logic [7:0][19:0] w;
      for (int g = 0; g < 8; g++) begin
         for (int i = 0; i < 20; i++) begin
            w[g][i] = lf[g][6];
            lf[g]   = {lf[g][5:0], lf[g][6] ^ lf[g][5]};
         end
      end
      raw = w;
   endtask

   task automatic apply_cfg(input logic [1:0] mode, input logic [7:0] en, input logic [7:0] cval,
                            input logic [15:0] p, input logic [15:0] h, input logic [31:0] burst);
      cfg_mode    = mode;
      cfg_lane_en = en;
      cfg_const   = cval;
      cfg_period  = p;
      cfg_high    = h;
      cfg_burst   = burst;
      cfg_valid   = 1'b1;
      cycle();
      cfg_valid   = 1'b0;
   endtask

   task automatic config_run(input logic [1:0] mode, input logic [7:0] en, input logic [7:0] cval,
                             input int p, input int h, input int burst);
      apply_cfg(mode, en, cval, 16'(p), 16'(h), 32'(burst));
      chk("cfg accepted", cfg_err, 1'b0);
      m_mode  = mode;
      m_en    = en;
      m_const = cval;
      m_p     = p;
      m_h     = h;
      cycle();
   endtask

   // stop_k < 2 means no stop; otherwise stop is sampled on the stop_k-th RUN edge.
   task automatic run_check(input string tag, input int stop_k, input int exp_words,
                            output logic [159:0] first_word);
      int           words, dones, first_k, done_k;
      logic [159:0] raw;
      words = 0; dones = 0; first_k = -1; done_k = -1; first_word = '0;
      for (int g = 0; g < 8; g++) lf[g] = 7'h7f ^ 7'(g);
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk({tag, " busy"}, busy, 1'b1);
      for (int k = 1; k <= exp_words + 10; k++) begin
         cycle();
         if (samples_valid) begin
            if (first_k < 0) begin
               first_k    = k;
               first_word = samples;
            end
            if (m_mode == 2'd3) prbs_model(raw);
            else raw = model_word(words);
            chk($sformatf("%s word%0d", tag, words), samples, finish_word(raw));
            words++;
         end
         if (done) begin
            dones++;
            done_k = k;
         end
         stop = (k == stop_k - 1);
      end
      stop = 1'b0;
      chk({tag, " latency"}, 160'(first_k), 160'(2));
      chk({tag, " words"}, 160'(words), 160'(exp_words));
      chk({tag, " done count"}, 160'(dones), 160'(1));
      chk({tag, " done cycle"}, 160'(done_k), 160'(exp_words + 2));
      chk({tag, " idle"}, busy, 1'b0);
   endtask

   initial begin
      cfg_vec_t     vecs[7];
      logic [159:0] fw;
      logic [7:0][19:0] fwl;
      int           dones;

      vecs[0] = '{2'd0, 8'hff, 8'h00, 16'd20,    16'd0,     1'b0, 8'h00};
      vecs[1] = '{2'd0, 8'h0f, 8'ha5, 16'd20,    16'd0,     1'b0, 8'h05};
      vecs[2] = '{2'd1, 8'hff, 8'h3c, 16'd19,    16'd0,     1'b1, 8'h05};
      vecs[3] = '{2'd1, 8'hff, 8'h3c, 16'd40,    16'd41,    1'b1, 8'h05};
      vecs[4] = '{2'd1, 8'hff, 8'h3c, 16'd40,    16'd40,    1'b0, 8'h3c};
`ifdef LOGIC_POD_PRBS_EN
      vecs[5] = '{2'd3, 8'hf0, 8'hff, 16'd20,    16'd0,     1'b0, 8'hf0};
`else
      vecs[5] = '{2'd3, 8'hf0, 8'hff, 16'd20,    16'd0,     1'b1, 8'h3c};
`endif
      vecs[6] = '{2'd2, 8'hff, 8'h00, 16'd65535, 16'd65535, 1'b0, 8'h00};

      rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
      cfg_mode = '0; cfg_lane_en = '0; cfg_const = '0;
      cfg_period = 16'd20; cfg_high = '0; cfg_burst = '0;
      repeat (3) cycle();
      rst = 1'b0;
      chk("reset samples", samples, park(8'h00));
      chk("reset cfg_ready", cfg_ready, 1'b1);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset valid", samples_valid, 1'b0);
      chk("reset cfg_err", cfg_err, 1'b0);

      for (int v = 0; v < 7; v++) begin
         apply_cfg(vecs[v].mode, vecs[v].en, vecs[v].cval, vecs[v].period, vecs[v].high, 32'd0);
         chk($sformatf("cfg_err vec%0d", v), cfg_err, vecs[v].err);
         cycle();
         chk($sformatf("cfg_err pulse vec%0d", v), cfg_err, 1'b0);
         cycle();
         chk($sformatf("park vec%0d", v), samples, park(vecs[v].park));
         chk($sformatf("cfg_ready vec%0d", v), cfg_ready, 1'b1);
      end

      config_run(2'd1, 8'hff, 8'h00, 40, 20, 6);
      run_check("square40", 0, 6, fw);
      fwl = fw;
      chk("square40 lane1 first", fwl[1], 20'hfffff);
      chk("square40 lane0 first", fwl[0], 20'h00000);

      config_run(2'd2, 8'hff, 8'h00, 20, 0, 3);
      run_check("count3", 0, 3, fw);
      fwl = fw;
      chk("count3 lane0 first", fwl[0], 20'h55555);
      chk("count3 lane1 first", fwl[1], 20'hccccc);

      config_run(2'd2, 8'hff, 8'h00, 20, 0, 20);
      run_check("count wrap", 0, 20, fw);

      config_run(2'd1, 8'h3c, 8'h00, 21, 7, 25);
      run_check("square21", 0, 25, fw);

      config_run(2'd1, 8'ha5, 8'h00, 65535, 30000, 3300);
      run_check("square65535", 0, 3300, fw);

`ifdef LOGIC_POD_PRBS_EN
      config_run(2'd3, 8'hff, 8'h00, 20, 0, 100);
      run_check("prbs7", 0, 100, fw);
`endif

      config_run(2'd2, 8'hff, 8'h00, 20, 0, 0);
      run_check("stop", 7, 7, fw);

      config_run(2'd2, 8'hff, 8'h00, 20, 0, 5);
      run_check("stop at burst end", 5, 5, fw);

      stop = 1'b1;
      cycle();
      stop = 1'b0;
      chk("stop in idle", busy, 1'b0);

      // Config offered during RUN must wait for IDLE.
      config_run(2'd2, 8'hff, 8'h00, 20, 0, 0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      cfg_mode = 2'd0; cfg_lane_en = 8'hff; cfg_const = 8'h81;
      cfg_period = 16'd20; cfg_high = 16'd0; cfg_burst = 32'd0;
      cfg_valid = 1'b1;
      cycle();
      cycle();
      chk("stall cfg_ready", cfg_ready, 1'b0);
      chk("stall cfg_err", cfg_err, 1'b0);
      chk("stall busy", busy, 1'b1);
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      chk("stall ready in idle", cfg_ready, 1'b1);
      cycle();
      cfg_valid = 1'b0;
      cycle();
      cycle();
      chk("stall park", samples, park(8'h81));

      config_run(2'd2, 8'hff, 8'h00, 20, 0, 0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (4) cycle();
      chk("pre-reset busy", busy, 1'b1);
      chk("pre-reset valid", samples_valid, 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mid-run reset busy", busy, 1'b0);
      chk("mid-run reset valid", samples_valid, 1'b0);
      chk("mid-run reset samples", samples, park(8'h00));
      dones = 0;
      repeat (6) begin
         cycle();
         if (done) dones++;
      end
      chk("mid-run reset no done", 160'(dones), 160'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
